sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 25 ++
 rtl/sdram_arb_select.sv | 42 ++++
 rtl/sdram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM port arbiter.
//   arb_state_e  - arbiter FSM state
//   port_idx_t   - requester index (PORT_FB / PORT_GPU / PORT_CPU)
//   port_onehot  - index to one-hot port vector
package sdram_arb_pkg;

  localparam int unsigned NUM_PORTS = 3;

  typedef logic [1:0] port_idx_t;

  localparam port_idx_t PORT_FB  = 2'd0;
  localparam port_idx_t PORT_GPU = 2'd1;
  localparam port_idx_t PORT_CPU = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd
  } arb_state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(port_idx_t idx);
    return NUM_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/sdram_arb_select.sv
// sdram_arb_select: combinational winner selection for the SDRAM port arbiter.
//   req_i        - per-port request
//   age_sat_i    - [0] GPU, [1] CPU: waiting request has been bypassed AGE_LIMIT cycles
//   rr_cpu_i     - round-robin pointer, 1 favours the CPU, 0 favours the GPU
//   grant_o      - one-hot grant (all zero when nobody requests)
//   grant_idx_o  - index of the granted port
module sdram_arb_select
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           age_sat_i,
  input  logic                 rr_cpu_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output port_idx_t            grant_idx_o
);

  logic rr_idx_cpu;

  always_comb begin
    rr_idx_cpu  = 1'b0;
    grant_idx_o = PORT_FB;
    // Starved GPU/CPU requests override the scanout priority.
    if (age_sat_i[0] && age_sat_i[1]) begin
      rr_idx_cpu  = rr_cpu_i;
      grant_idx_o = rr_idx_cpu ? PORT_CPU : PORT_GPU;
    end else if (age_sat_i[0]) begin
      grant_idx_o = PORT_GPU;
    end else if (age_sat_i[1]) begin
      grant_idx_o = PORT_CPU;
    end else if (req_i[PORT_FB]) begin
      grant_idx_o = PORT_FB;
    end else if (req_i[PORT_GPU] && req_i[PORT_CPU]) begin
      grant_idx_o = rr_cpu_i ? PORT_CPU : PORT_GPU;
    end else if (req_i[PORT_GPU]) begin
      grant_idx_o = PORT_GPU;
    end else if (req_i[PORT_CPU]) begin
      grant_idx_o = PORT_CPU;
    end
    grant_o = (|req_i) ? port_onehot(grant_idx_o) : '0;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command port between the
// framebuffer scanout (port 0, fixed priority), the GPU (port 1) and the CPU
// bridge (port 2, round-robin with port 1, age-limited starvation guard).
//   clk, reset                  - clock, asynchronous active-high reset
//   req/req_addr/req_we/
//   req_wdata/req_wmask         - per-port request and command fields
//   req_ready                   - accept pulse, same cycle as the controller handshake
//   rsp_valid/rsp_data          - read data back to the owning port, one cycle after ctrl_rvalid
//   ctrl_*                      - command/read-data interface to the SDRAM controller
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AGE_LIMIT = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_wdata,
  input  logic [NUM_PORTS-1:0][1:0]         req_wmask,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [DATA_W-1:0]                 rsp_data,
  output logic                              ctrl_valid,
  input  logic                              ctrl_ready,
  output logic [ADDR_W-1:0]                 ctrl_addr,
  output logic                              ctrl_we,
  output logic [DATA_W-1:0]                 ctrl_wdata,
  output logic [1:0]                        ctrl_dqm,
  input  logic                              ctrl_rvalid,
  input  logic [DATA_W-1:0]                 ctrl_rdata
);

  localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
  typedef logic [AgeW-1:0] age_t;
  localparam age_t AgeMax = age_t'(AGE_LIMIT);

  arb_state_e state_q, state_d;

  port_idx_t             owner_q;
  logic                  rr_cpu_q;
  logic [ADDR_W-1:0]     ctrl_addr_q;
  logic                  ctrl_we_q;
  logic [DATA_W-1:0]     ctrl_wdata_q;
  logic [1:0]            ctrl_dqm_q;
  logic [NUM_PORTS-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_data_q;
  // Index 0 tracks the GPU, index 1 the CPU.
  logic [1:0][AgeW-1:0]  age_q, age_d;
  logic [1:0]            age_sat;

  logic [NUM_PORTS-1:0]  grant;
  port_idx_t             grant_idx;
  logic                  launch;
  logic                  rd_done;

  sdram_arb_select u_select (
    .req_i       (req),
    .age_sat_i   (age_sat),
    .rr_cpu_i    (rr_cpu_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (|grant) state_d = StIssue;
      StIssue:  if (ctrl_ready) state_d = ctrl_we_q ? StIdle : StWaitRd;
      StWaitRd: if (ctrl_rvalid) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs and handshake strobes.
  always_comb begin
    launch     = (state_q == StIdle) && (|grant);
    rd_done    = (state_q == StWaitRd) && ctrl_rvalid;
    ctrl_valid = (state_q == StIssue);
    req_ready  = (ctrl_valid && ctrl_ready) ? port_onehot(owner_q) : '0;
  end

  // Age counters: a waiting GPU/CPU request ages every cycle it is not the owner.
  always_comb begin
    age_d   = age_q;
    age_sat = '0;
    for (int i = 0; i < 2; i++) begin
      age_sat[i] = req[i+1] && (age_q[i] == AgeMax);
      if (!req[i+1]) begin
        age_d[i] = '0;
      end else if (launch && (grant_idx == port_idx_t'(i + 1))) begin
        age_d[i] = '0;
      end else if ((state_q != StIdle) && (owner_q == port_idx_t'(i + 1))) begin
        age_d[i] = age_q[i];
      end else if (age_q[i] != AgeMax) begin
        age_d[i] = age_q[i] + age_t'(1);
      end
    end
  end

  // Command latch, response path and arbitration bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= PORT_FB;
      rr_cpu_q     <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_we_q    <= 1'b0;
      ctrl_wdata_q <= '0;
      ctrl_dqm_q   <= 2'b00;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      age_q        <= '0;
    end else begin
      if (launch) begin
        owner_q      <= grant_idx;
        ctrl_addr_q  <= req_addr[grant_idx];
        ctrl_we_q    <= req_we[grant_idx];
        ctrl_wdata_q <= req_wdata[grant_idx];
        // DQM is an active-high mask; reads always return both bytes.
        ctrl_dqm_q   <= req_we[grant_idx] ? ~req_wmask[grant_idx] : 2'b00;
        if (grant_idx != PORT_FB) rr_cpu_q <= (grant_idx == PORT_GPU);
      end
      rsp_valid_q <= rd_done ? port_onehot(owner_q) : '0;
      if (rd_done) rsp_data_q <= ctrl_rdata;
      age_q <= age_d;
    end
  end

  assign ctrl_addr  = ctrl_addr_q;
  assign ctrl_we    = ctrl_we_q;
  assign ctrl_wdata = ctrl_wdata_q;
  assign ctrl_dqm   = ctrl_dqm_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (AGE_LIMIT = 8).
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int AL = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [2:0]          req;
  logic [2:0][AW-1:0]  req_addr;
  logic [2:0]          req_we;
  logic [2:0][DW-1:0]  req_wdata;
  logic [2:0][1:0]     req_wmask;
  logic [2:0]          req_ready;
  logic [2:0]          rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                ctrl_valid;
  logic                ctrl_ready;
  logic [AW-1:0]       ctrl_addr;
  logic                ctrl_we;
  logic [DW-1:0]       ctrl_wdata;
  logic [1:0]          ctrl_dqm;
  logic                ctrl_rvalid;
  logic [DW-1:0]       ctrl_rdata;

  int tests = 0;
  int fails = 0;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AGE_LIMIT(AL)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .ctrl_addr   (ctrl_addr),
    .ctrl_we     (ctrl_we),
    .ctrl_wdata  (ctrl_wdata),
    .ctrl_dqm    (ctrl_dqm),
    .ctrl_rvalid (ctrl_rvalid),
    .ctrl_rdata  (ctrl_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 7;
    endcase
  endfunction

  int got[10];
  int got_c[10];
  int n;
  int last_c;
  int exp_rr[6]   = '{0, 1, 2, 0, 1, 2};
  int exp_age[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_alt[4]  = '{1, 2, 1, 2};
  logic [1:0] wmask_tab[3] = '{2'b01, 2'b10, 2'b11};
  logic [1:0] dqm_tab[3]   = '{2'b10, 2'b01, 2'b00};

  initial begin
    req = '0; req_addr = '0; req_we = '0; req_wdata = '0; req_wmask = '0;
    ctrl_ready = 1'b0; ctrl_rvalid = 1'b0; ctrl_rdata = '0;
    reset = 1'b1;
    cyc(); cyc();

    // Reset values.
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ctrl_valid", ctrl_valid, 0);
    chk("rst_ctrl_addr", ctrl_addr, 0);
    chk("rst_ctrl_we", ctrl_we, 0);
    chk("rst_ctrl_wdata", ctrl_wdata, 0);
    chk("rst_ctrl_dqm", ctrl_dqm, 0);
    reset = 1'b0;
    cyc();

    // Single CPU read of 0x000123.
    req[2] = 1'b1; req_addr[2] = 24'h000123; req_we[2] = 1'b0; req_wmask[2] = 2'b11;
    #1 chk("t1_valid_n", ctrl_valid, 0);
    cyc();
    chk("t1_valid_n1", ctrl_valid, 1);
    chk("t1_addr", ctrl_addr, 32'h123);
    chk("t1_we", ctrl_we, 0);
    chk("t1_dqm", ctrl_dqm, 0);
    chk("t1_ready_early", req_ready, 0);
    cyc();
    chk("t1_valid_hold", ctrl_valid, 1);
    cyc();
    ctrl_ready = 1'b1;
    #1 chk("t1_req_ready", req_ready, 3'b100);
    cyc();
    ctrl_ready = 1'b0; req[2] = 1'b0;
    #1 chk("t1_wait_valid", ctrl_valid, 0);
    cyc(); cyc(); cyc(); cyc();
    ctrl_rvalid = 1'b1; ctrl_rdata = 16'hBEEF;
    #1 chk("t1_rsp_early", rsp_valid, 0);
    cyc();
    ctrl_rvalid = 1'b0; ctrl_rdata = '0;
    #1 chk("t1_rsp_valid", rsp_valid, 3'b100);
    chk("t1_rsp_data", rsp_data, 32'hBEEF);
    cyc();
    chk("t1_rsp_pulse", rsp_valid, 0);

    // All three ports write once per round, controller always ready.
    for (int p = 0; p < 3; p++) begin
      req_addr[p] = AW'(32'h100 + p); req_wdata[p] = DW'(32'hA000 + p);
      req_we[p] = 1'b1; req_wmask[p] = wmask_tab[p];
    end
    ctrl_ready = 1'b1;
    n = 0;
    for (int r = 0; r < 2; r++) begin
      req = 3'b111;
      last_c = -1;
      for (int c = 0; c < 20 && req != 3'b000; c++) begin
        #1;
        if (req_ready != 3'b000) begin
          if (n < 6) got[n] = oh2idx(req_ready);
          if (oh2idx(req_ready) < 3) begin
            chk("t2_dqm", ctrl_dqm, dqm_tab[oh2idx(req_ready)]);
            chk("t2_wdata", ctrl_wdata, 32'hA000 + oh2idx(req_ready));
          end
          if (last_c >= 0) chk("t2_turnaround", c - last_c, 2);
          last_c = c;
          n++;
          req = req & ~req_ready;
        end
        cyc();
      end
      chk("t2_round_done", req, 0);
    end
    chk("t2_count", n, 6);
    for (int i = 0; i < 6; i++) chk("t2_order", got[i], exp_rr[i]);

    // Port 0 continuous, GPU waiting: GPU forced through when its age saturates.
    req[0] = 1'b1; req[1] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      #1;
      if (req_ready != 3'b000) begin
        got[n] = oh2idx(req_ready);
        got_c[n] = c;
        n++;
      end
      cyc();
    end
    req = '0;
    chk("t3_count", n, 10);
    for (int i = 0; i < 10; i++) chk("t3_order", got[i], exp_age[i]);
    chk("t3_first_gpu_cycle", got_c[4], 9);
    chk("t3_gpu_gap", got_c[9] - got_c[4], 10);
    cyc();

    // Fresh reset: GPU and CPU alone alternate, starting with the GPU.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    req[1] = 1'b1; req[2] = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      #1;
      if (req_ready != 3'b000) begin
        got[n] = oh2idx(req_ready);
        n++;
      end
      cyc();
    end
    req = '0;
    chk("t4_count", n, 4);
    for (int i = 0; i < 4; i++) chk("t4_order", got[i], exp_alt[i]);
    cyc();

    // Spurious read data in IDLE is ignored.
    ctrl_ready = 1'b0;
    ctrl_rvalid = 1'b1; ctrl_rdata = 16'h1234;
    cyc();
    ctrl_rvalid = 1'b0; ctrl_rdata = '0;
    #1 chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_ctrl_valid", ctrl_valid, 0);
    cyc();
    chk("t5_rsp_valid_late", rsp_valid, 0);

    // Reset while a GPU read is outstanding.
    req[1] = 1'b1; req_addr[1] = 24'h00ABCD; req_we[1] = 1'b0;
    cyc();
    ctrl_ready = 1'b1;
    #1 chk("t6_req_ready", req_ready, 3'b010);
    chk("t6_addr", ctrl_addr, 32'hABCD);
    cyc();
    req = '0; ctrl_ready = 1'b0;
    #1 chk("t6_wait_valid", ctrl_valid, 0);
    reset = 1'b1; ctrl_rvalid = 1'b1; ctrl_rdata = 16'h5A5A;
    #1 chk("t6_rst_addr", ctrl_addr, 0);
    chk("t6_rst_we", ctrl_we, 0);
    chk("t6_rst_valid", ctrl_valid, 0);
    chk("t6_rst_rsp", rsp_valid, 0);
    cyc();
    chk("t6_rst_rsp_hold", rsp_valid, 0);
    reset = 1'b0; ctrl_rvalid = 1'b0; ctrl_rdata = '0;
    cyc();
    chk("t6_post_rsp", rsp_valid, 0);
    chk("t6_post_data", rsp_data, 0);
    // Arbiter must be back in IDLE and accept new work.
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 24'h000042;
    cyc();
    chk("t6_new_valid", ctrl_valid, 1);
    chk("t6_new_addr", ctrl_addr, 32'h42);
    chk("t6_post_rsp2", rsp_valid, 0);
    ctrl_ready = 1'b1;
    #1 chk("t6_new_ready", req_ready, 3'b001);
    cyc();
    req = '0; ctrl_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
